// File: rtl/uart_msg_reader_pkg.sv
// Shared definitions for the UART message reader: size defaults, a ceiling-log2
// helper for address widths, and the reader FSM state type.
package uart_msg_reader_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int LEN_DEF   = 256;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/uart_msg_reader.sv
// Reads a message of up to LEN bytes out of the message RAM in address order and
// presents each byte to the UART transmitter over a valid/ready interface.
module uart_msg_reader
  import uart_msg_reader_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int LEN   = LEN_DEF,
  localparam int AW    = clog2(LEN - 1) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             msg_valid,
  input  logic [AW-1:0]    msg_len,
  output logic             msg_ready,
  output logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] LEN_AW = AW'(LEN);

  state_t           state_reg,    state_next;
  logic [AW-1:0]    len_reg,      len_next;
  logic [AW-1:0]    idx_reg,      idx_next;
  logic [AW-1:0]    addr_reg,     addr_next;
  logic [WIDTH-1:0] tx_data_reg,  tx_data_next;
  logic             tx_valid_reg, tx_valid_next;
  logic             busy_reg,     busy_next;
  logic [AW-1:0]    idx_plus1;

  // Last byte is detected as idx+1==len so len-1 is never formed.
  assign idx_plus1 = idx_reg + AW'(1);

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    idx_next      = idx_reg;
    addr_next     = addr_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    busy_next     = busy_reg;
    case (state_reg)
      ST_IDLE: begin
        if (msg_valid) begin
          len_next   = (msg_len > LEN_AW) ? LEN_AW : msg_len;
          idx_next   = '0;
          addr_next  = '0;
          busy_next  = 1'b1;
          state_next = (msg_len == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: state_next = ST_LOAD;
      ST_LOAD: begin
        tx_data_next  = dout;
        tx_valid_next = 1'b1;
        state_next    = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          tx_valid_next = 1'b0;
          if (idx_plus1 == len_reg) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = idx_plus1;
            addr_next  = idx_plus1;
            state_next = ST_READ;
          end
        end
      end
      ST_DONE: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      idx_reg      <= '0;
      addr_reg     <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      idx_reg      <= idx_next;
      addr_reg     <= addr_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      busy_reg     <= busy_next;
    end
  end

  assign msg_ready = (state_reg == ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign addr      = addr_reg;
  assign tx_data   = tx_data_reg;
  assign tx_valid  = tx_valid_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_uart_msg_reader.sv
// Self-checking bench for uart_msg_reader: table of messages plus random ones,
// with a RAM model, a handshake monitor and a queue-based expected-byte model.
module tb_uart_msg_reader;

  localparam int WIDTH = 8;
  localparam int LEN   = 256;
  localparam int AW    = 9;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             msg_valid;
  logic [AW-1:0]    msg_len;
  logic             msg_ready;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  uart_msg_reader #(.WIDTH(WIDTH), .LEN(LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_valid (msg_valid),
    .msg_len   (msg_len),
    .msg_ready (msg_ready),
    .addr      (addr),
    .dout      (dout),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  // Message RAM with one-cycle registered read
  logic [7:0] ram [LEN];
  always @(posedge clk) dout <= ram[addr[7:0]];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: collects accepted bytes, done pulses, max address, stall stability
  logic [7:0] got [$];
  int   cyc = 0;
  int   done_total = 0;
  int   done_cyc = 0;
  int   last_hs_cyc = 0;
  int   max_addr = 0;
  int   stall_err = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && tx_valid && tx_ready) begin
      got.push_back(tx_data);
      last_hs_cyc <= cyc;
    end
    if (rst_n && done) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
    end
    if (rst_n && msg_valid && msg_ready) max_addr <= 0;
    else if (busy && int'(addr) > max_addr) max_addr <= int'(addr);
    if (rst_n && prev_stall && (!tx_valid || tx_data != prev_data))
      stall_err <= stall_err + 1;
    prev_stall <= rst_n && tx_valid && !tx_ready;
    prev_data  <= tx_data;
  end

  // tx_ready driver: 0 = always ready, 1 = 10-cycle stall per byte, 2 = random
  int ready_mode = 0;
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_valid) wait_cnt++;
      else wait_cnt = 0;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (wait_cnt > 10);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic fill_ram(input int fill);
    for (int i = 0; i < LEN; i++) begin
      case (fill)
        1:       ram[i] = 8'(i);
        2:       ram[i] = 8'(8'h41 + i);
        default: ram[i] = 8'($urandom);
      endcase
    end
  endtask

  // inject: -1 none, -2 coincident with done, k>=0 extra msg_valid k cycles after accept
  task automatic run_msg(input int len, input int mode, input int fill,
                         input int inject, input int exp_n, input string tag);
    int start, d0, s0, first_valid, done_at, limit, n_got;
    bit seen;
    fill_ram(fill);
    ready_mode  = mode;
    start       = got.size();
    d0          = done_total;
    s0          = stall_err;
    first_valid = -1;
    done_at     = -1;
    seen        = 1'b0;
    limit       = 30 * len + 60;
    check({tag, " msg_ready"}, int'(msg_ready), 1);
    msg_valid = 1'b1;
    msg_len   = AW'(len);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      msg_valid = (k == inject);
      if (msg_valid) msg_len = AW'(7);
      if (first_valid < 0 && tx_valid) first_valid = k + 1;
      if (done) begin
        seen    = 1'b1;
        done_at = k + 1;
        if (inject == -2) begin
          msg_valid = 1'b1;
          msg_len   = AW'(7);
        end
        break;
      end
    end
    check({tag, " done seen"}, int'(seen), 1);
    @(negedge clk);
    msg_valid = 1'b0;
    check({tag, " busy after done"}, int'(busy), 0);
    repeat (3) @(negedge clk);
    check({tag, " idle tx_valid"}, int'(tx_valid), 0);
    check({tag, " idle msg_ready"}, int'(msg_ready), 1);
    n_got = got.size() - start;
    check({tag, " byte count"}, n_got, exp_n);
    for (int i = 0; i < exp_n && i < n_got; i++)
      check($sformatf("%s byte[%0d]", tag, i), int'(got[start + i]), int'(ram[i]));
    check({tag, " done pulses"}, done_total - d0, 1);
    check({tag, " stall stable"}, stall_err - s0, 0);
    if (exp_n > 0) begin
      check({tag, " first tx_valid latency"}, first_valid, 3);
      check({tag, " max addr"}, max_addr, exp_n - 1);
      check({tag, " done after last hs"}, done_cyc - last_hs_cyc, 1);
    end else begin
      check({tag, " no tx_valid"}, first_valid, -1);
      check({tag, " done latency"}, done_at, 1);
    end
    $display("msg %s len=%0d mode=%0d bytes=%0d", tag, len, mode, n_got);
  endtask

  typedef struct {
    int len;
    int mode;
    int fill;
    int inject;
    int exp_n;
  } vec_t;

  initial begin
    vec_t tbl [9];
    int   start, len, exp_n;
    bit   reached;

    tbl[0] = '{len: 3,   mode: 0, fill: 2, inject: -1, exp_n: 3};
    tbl[1] = '{len: 3,   mode: 1, fill: 2, inject: -1, exp_n: 3};
    tbl[2] = '{len: 0,   mode: 0, fill: 0, inject: -1, exp_n: 0};
    tbl[3] = '{len: 300, mode: 0, fill: 1, inject: -1, exp_n: 256};
    tbl[4] = '{len: 5,   mode: 2, fill: 0, inject: -1, exp_n: 5};
    tbl[5] = '{len: 5,   mode: 0, fill: 0, inject: 4,  exp_n: 5};
    tbl[6] = '{len: 4,   mode: 0, fill: 0, inject: -2, exp_n: 4};
    tbl[7] = '{len: 256, mode: 2, fill: 0, inject: -1, exp_n: 256};
    tbl[8] = '{len: 17,  mode: 1, fill: 0, inject: 2,  exp_n: 17};

    rst_n     = 1'b0;
    msg_valid = 1'b0;
    msg_len   = '0;
    fill_ram(0);
    repeat (3) @(negedge clk);
    check("reset tx_valid", int'(tx_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset addr", int'(addr), 0);
    check("reset tx_data", int'(tx_data), 0);
    check("reset msg_ready", int'(msg_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 9; t++)
      run_msg(tbl[t].len, tbl[t].mode, tbl[t].fill, tbl[t].inject, tbl[t].exp_n,
              $sformatf("tbl%0d", t));

    // Reset after the 2nd handshake of a 5-byte message
    fill_ram(0);
    ready_mode = 0;
    start      = got.size();
    reached    = 1'b0;
    msg_valid  = 1'b1;
    msg_len    = AW'(5);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      msg_valid = 1'b0;
      if (got.size() - start >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    check("rst 2nd handshake reached", int'(reached), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst tx_valid", int'(tx_valid), 0);
    check("rst busy", int'(busy), 0);
    check("rst addr", int'(addr), 0);
    check("rst msg_ready", int'(msg_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst bytes before abort", got.size() - start, 2);
    $display("msg rst abort after %0d bytes", got.size() - start);
    run_msg(2, 0, 0, -1, 2, "after_rst");

    // Random messages checked against min(len, LEN) bytes of RAM
    for (int r = 0; r < 6; r++) begin
      len   = int'($urandom_range(0, 300));
      exp_n = (len > LEN) ? LEN : len;
      run_msg(len, 2, 0, -1, exp_n, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
